// File: rtl/m_stage_dm_pkg.sv
// Shared definitions for the M-stage data memory: memory opcodes, access widths,
// memory geometry and the opcode decoder used by the top level.
package m_stage_dm_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam int unsigned DM_BASE        = 32'd0;
  localparam int unsigned DM_DEPTH_WORDS = 32'd3072;

  typedef enum logic [1:0] {
    W_NONE = 2'd0,
    W_BYTE = 2'd1,
    W_HALF = 2'd2,
    W_WORD = 2'd3
  } acc_width_e;

  typedef struct packed {
    acc_width_e width;
    logic       is_load;
    logic       is_store;
    logic       is_signed;
  } mem_op_t;

  // Non-memory opcodes decode to W_NONE with no load/store flag set.
  function automatic mem_op_t decode_op(input logic [5:0] opcode);
    mem_op_t op;
    op = '{width: W_NONE, is_load: 1'b0, is_store: 1'b0, is_signed: 1'b0};
    case (opcode)
      OP_LW:   op = '{width: W_WORD, is_load: 1'b1, is_store: 1'b0, is_signed: 1'b0};
      OP_LH:   op = '{width: W_HALF, is_load: 1'b1, is_store: 1'b0, is_signed: 1'b1};
      OP_LHU:  op = '{width: W_HALF, is_load: 1'b1, is_store: 1'b0, is_signed: 1'b0};
      OP_LB:   op = '{width: W_BYTE, is_load: 1'b1, is_store: 1'b0, is_signed: 1'b1};
      OP_LBU:  op = '{width: W_BYTE, is_load: 1'b1, is_store: 1'b0, is_signed: 1'b0};
      OP_SW:   op = '{width: W_WORD, is_load: 1'b0, is_store: 1'b1, is_signed: 1'b0};
      OP_SH:   op = '{width: W_HALF, is_load: 1'b0, is_store: 1'b1, is_signed: 1'b0};
      OP_SB:   op = '{width: W_BYTE, is_load: 1'b0, is_store: 1'b1, is_signed: 1'b0};
      default: op = '{width: W_NONE, is_load: 1'b0, is_store: 1'b0, is_signed: 1'b0};
    endcase
    return op;
  endfunction

endpackage

// File: rtl/m_stage_dm_if.sv
// EX/MEM-to-memory bus: pipeline request fields, load result/error and the
// write-log record for the trace.
interface m_stage_dm_if;

  logic [31:0] addr_m;
  logic [31:0] wdata_m;
  logic [31:0] instr_m;
  logic [31:0] pc_m;
  logic        mem_write_m;
  logic [31:0] rdata_m;
  logic        addr_err_m;
  logic        wlog_valid;
  logic [31:0] wlog_pc;
  logic [31:0] wlog_addr;
  logic [31:0] wlog_data;

  modport master (
    output addr_m, wdata_m, instr_m, pc_m, mem_write_m,
    input  rdata_m, addr_err_m, wlog_valid, wlog_pc, wlog_addr, wlog_data
  );

  modport slave (
    input  addr_m, wdata_m, instr_m, pc_m, mem_write_m,
    output rdata_m, addr_err_m, wlog_valid, wlog_pc, wlog_addr, wlog_data
  );

endinterface

// File: rtl/m_stage_dm_load_ext.sv
// Load extractor: picks the addressed byte/half out of a word and sign- or
// zero-extends it; words pass through unchanged.
module dm_load_ext
  import m_stage_dm_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  acc_width_e  width_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [15:0] half_s;
  logic [7:0]  byte_s;

  // Lane select and extension.
  always_comb begin
    half_s = 16'h0000;
    byte_s = 8'h00;
    data_o = 32'h0000_0000;
    case (width_i)
      W_WORD: data_o = word_i;
      W_HALF: begin
        half_s = lane_i[1] ? word_i[31:16] : word_i[15:0];
        data_o = {{16{signed_i & half_s[15]}}, half_s};
      end
      W_BYTE: begin
        byte_s = word_i[{lane_i, 3'b000} +: 8];
        data_o = {{24{signed_i & byte_s[7]}}, byte_s};
      end
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/m_stage_dm.sv
// M-stage data memory: byte-enabled stores into a flop array cleared by reset,
// same-cycle extended loads, alignment/range error flag and a registered write log.
module m_stage_dm
  import m_stage_dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter int unsigned AW          = 14
) (
  input  logic          clk,
  input  logic          reset,
  m_stage_dm_if.slave   bus
);

  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

  logic [31:0]   mem_q [DEPTH_WORDS];

  mem_op_t       op_s;
  logic [AW-3:0] widx_s;
  logic [1:0]    lane_s;
  logic          is_mem_s;
  logic          in_range_s;
  logic          misalign_s;
  logic          addr_err_s;
  logic          commit_s;
  logic [31:0]   old_word_s;
  logic [3:0]    be_s;
  logic [31:0]   wlane_s;
  logic [31:0]   merged_s;
  logic [31:0]   ext_s;

  logic          wlog_valid_q, wlog_valid_d;
  logic [31:0]   wlog_pc_q,    wlog_pc_d;
  logic [31:0]   wlog_addr_q,  wlog_addr_d;
  logic [31:0]   wlog_data_q,  wlog_data_d;

  assign op_s       = decode_op(bus.instr_m[31:26]);
  assign widx_s     = bus.addr_m[AW-1:2];
  assign lane_s     = bus.addr_m[1:0];
  assign is_mem_s   = op_s.is_load | op_s.is_store;
  // Comparing the full 32-bit address makes any high bit an out-of-range access.
  assign in_range_s = (bus.addr_m < LIMIT);
  assign old_word_s = in_range_s ? mem_q[widx_s] : 32'h0000_0000;

  // Alignment requirement depends on access width.
  always_comb begin
    misalign_s = 1'b0;
    case (op_s.width)
      W_WORD:  misalign_s = (lane_s != 2'b00);
      W_HALF:  misalign_s = lane_s[0];
      default: misalign_s = 1'b0;
    endcase
  end

  assign addr_err_s = is_mem_s & (misalign_s | ~in_range_s);
  assign commit_s   = bus.mem_write_m & op_s.is_store & ~addr_err_s & ~reset;

  // Byte enables and store data replicated onto every lane.
  always_comb begin
    be_s    = 4'b0000;
    wlane_s = bus.wdata_m;
    case (op_s.width)
      W_WORD: begin
        be_s    = 4'b1111;
        wlane_s = bus.wdata_m;
      end
      W_HALF: begin
        be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
        wlane_s = {2{bus.wdata_m[15:0]}};
      end
      W_BYTE: begin
        be_s    = 4'b0001 << lane_s;
        wlane_s = {4{bus.wdata_m[7:0]}};
      end
      default: begin
        be_s    = 4'b0000;
        wlane_s = bus.wdata_m;
      end
    endcase
  end

  // Byte-enable merge of the store data into the current word.
  always_comb begin
    merged_s = old_word_s;
    for (int b = 0; b < 4; b++) begin
      if (be_s[b]) begin
        merged_s[8*b +: 8] = wlane_s[8*b +: 8];
      end else begin
        merged_s[8*b +: 8] = old_word_s[8*b +: 8];
      end
    end
  end

  // Array: wholly cleared in the reset cycle, otherwise written on commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (commit_s) begin
      mem_q[widx_s] <= merged_s;
    end
  end

  dm_load_ext u_load_ext (
    .word_i   (old_word_s),
    .lane_i   (lane_s),
    .width_i  (op_s.width),
    .signed_i (op_s.is_signed),
    .data_o   (ext_s)
  );

  assign bus.rdata_m    = (op_s.is_load & ~addr_err_s) ? ext_s : 32'h0000_0000;
  assign bus.addr_err_m = addr_err_s;

  // Log next state: fields hold between stores, valid pulses per commit.
  always_comb begin
    wlog_valid_d = 1'b0;
    wlog_pc_d    = wlog_pc_q;
    wlog_addr_d  = wlog_addr_q;
    wlog_data_d  = wlog_data_q;
    if (commit_s) begin
      wlog_valid_d = 1'b1;
      wlog_pc_d    = bus.pc_m;
      wlog_addr_d  = {bus.addr_m[31:2], 2'b00};
      wlog_data_d  = merged_s;
    end else begin
      wlog_valid_d = 1'b0;
    end
  end

  // Log register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wlog_valid_q <= 1'b0;
      wlog_pc_q    <= 32'h0000_0000;
      wlog_addr_q  <= 32'h0000_0000;
      wlog_data_q  <= 32'h0000_0000;
    end else begin
      wlog_valid_q <= wlog_valid_d;
      wlog_pc_q    <= wlog_pc_d;
      wlog_addr_q  <= wlog_addr_d;
      wlog_data_q  <= wlog_data_d;
    end
  end

  assign bus.wlog_valid = wlog_valid_q;
  assign bus.wlog_pc    = wlog_pc_q;
  assign bus.wlog_addr  = wlog_addr_q;
  assign bus.wlog_data  = wlog_data_q;

endmodule
